// File: rtl/vstore_pkg.sv
// ----------------------------------------------------------------------------
// vstore_pkg
// Shared definitions for the vector store data aligner: element size
// encodings, aligner state encoding and a helper that turns a size code
// into a byte-count-minus-one mask.
// Ports: none (package).
// ----------------------------------------------------------------------------
package vstore_pkg;

    // Widest element the aligner ever receives, in bits.
    localparam int ELEM_W = 64;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_HOLD_LO = 2'd2
    } state_e;

    // Returns n-1 where n = 2^size bytes; doubles as the alignment mask.
    function automatic logic [2:0] size_mask(input logic [1:0] size);
        logic [2:0] mask;
        case (size)
            SZ_BYTE:  mask = 3'd0;
            SZ_HALF:  mask = 3'd1;
            SZ_WORD:  mask = 3'd3;
            default:  mask = 3'd7;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/vstore_lane_shift.sv
// ----------------------------------------------------------------------------
// vstore_lane_shift
// Combinational byte-lane placer. Takes a least-significant-justified element
// and places it big-endian on a DW-bit bus starting at byte offset i_offset
// (element MS byte at the lowest offset). Bytes that run past the end of the
// bus land in the "hi" beat starting at lane offset 0.
// Ports:
//   i_offset      byte offset within the bus word
//   i_size        element size code (0 byte .. 3 doubleword)
//   i_data        element data, least-significant justified
//   o_byteena_lo  byte enables of the first beat
//   o_data_lo     data of the first beat
//   o_byteena_hi  byte enables of the overflow beat
//   o_data_hi     data of the overflow beat
//   o_split       element crosses the bus word boundary
// ----------------------------------------------------------------------------
module vstore_lane_shift
    import vstore_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic [$clog2(DW/8)-1:0] i_offset,
    input  logic [1:0]              i_size,
    input  logic [ELEM_W-1:0]       i_data,
    output logic [DW/8-1:0]         o_byteena_lo,
    output logic [DW-1:0]           o_data_lo,
    output logic [DW/8-1:0]         o_byteena_hi,
    output logic [DW-1:0]           o_data_hi,
    output logic                    o_split
);

    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);

    logic [2:0]        w_nm1;
    logic [ELEM_W-1:0] w_ms;
    logic [7:0]        w_mask;
    logic [2*DW-1:0]   w_wide_data;
    logic [2*NB-1:0]   w_wide_en;
    logic [OW:0]       w_last_byte;

    // The element is first moved to the top of a 64-bit field (which also
    // drops any junk above its n bytes), then dropped into a double-width
    // window and shifted right by the offset. The upper half of the window is
    // the first beat, the lower half is whatever spilled into the next word.
    always_comb begin
        w_nm1       = size_mask(i_size);
        w_ms        = i_data << {3'd7 - w_nm1, 3'b000};
        w_mask      = 8'hFF << (3'd7 - w_nm1);
        w_wide_data = {w_ms, {(2*DW-ELEM_W){1'b0}}} >> {i_offset, 3'b000};
        w_wide_en   = {w_mask, {(2*NB-8){1'b0}}} >> i_offset;
        w_last_byte = {1'b0, i_offset} + (OW+1)'(w_nm1);
    end

    assign o_data_lo    = w_wide_data[2*DW-1:DW];
    assign o_data_hi    = w_wide_data[DW-1:0];
    assign o_byteena_lo = w_wide_en[2*NB-1:NB];
    assign o_byteena_hi = w_wide_en[NB-1:0];
    assign o_split      = (w_last_byte >= (OW+1)'(NB));

endmodule

// File: rtl/vstore_data_aligner.sv
// ----------------------------------------------------------------------------
// vstore_data_aligner
// Turns store elements (byte..doubleword at any byte address) into aligned
// DW-bit bus beats with big-endian byte lanes and byte enables. One element
// per cycle throughput when the bus keeps up.
// Configuration macro: VSTORE_SPLIT_UNALIGNED_EN
//   defined   - misaligned elements are stored at their true address and an
//               element that crosses a bus word goes out as two beats;
//               misalign_err is held 0.
//   undefined - the address is rounded down to the element size and
//               misalign_err pulses for one cycle after such an element.
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   in_valid/ready  element handshake; in_data/in_addr/in_size element
//   out_valid/ready beat handshake; out_addr/out_byteena/out_data/out_last
//   misalign_err    misaligned element indication
// ----------------------------------------------------------------------------
module vstore_data_aligner
    import vstore_pkg::*;
#(
    parameter int DW = 64,
    parameter int AW = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    input  logic [AW-1:0]     in_addr,
    input  logic [1:0]        in_size,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW-1:0]     out_addr,
    output logic [DW/8-1:0]   out_byteena,
    output logic [DW-1:0]     out_data,
    output logic              out_last,
    output logic              misalign_err
);

    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);

`ifdef VSTORE_SPLIT_UNALIGNED_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    state_e          r_state;
    logic [AW-1:0]   r_addr;
    logic [NB-1:0]   r_byteena;
    logic [DW-1:0]   r_data;
    logic            r_last;
    logic [NB-1:0]   r_hi_byteena;
    logic [DW-1:0]   r_hi_data;
    logic            r_misalign;

    logic [OW-1:0]   w_offset;
    logic [OW-1:0]   w_size_mask;
    logic [OW-1:0]   w_lane_offset;
    logic            w_misaligned;
    logic            w_accept;
    logic            w_consume;
    logic [NB-1:0]   w_en_lo;
    logic [NB-1:0]   w_en_hi;
    logic [DW-1:0]   w_data_lo;
    logic [DW-1:0]   w_data_hi;
    logic            w_split;

    assign w_offset    = in_addr[OW-1:0];
    assign w_size_mask = OW'(size_mask(in_size));
    assign w_misaligned = |(w_offset & w_size_mask);

    // Without split support the element is pulled back to its natural
    // alignment, so it can never cross a bus word and HOLD_LO is never entered.
    assign w_lane_offset = SPLIT_EN ? w_offset : (w_offset & ~w_size_mask);

    assign in_ready  = (r_state == ST_EMPTY) | ((r_state == ST_HOLD) & out_ready);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_accept  = in_valid & in_ready;
    assign w_consume = out_valid & out_ready;

    vstore_lane_shift #(
        .DW (DW)
    ) u_lane_shift (
        .i_offset     (w_lane_offset),
        .i_size       (in_size),
        .i_data       (in_data),
        .o_byteena_lo (w_en_lo),
        .o_data_lo    (w_data_lo),
        .o_byteena_hi (w_en_hi),
        .o_data_hi    (w_data_hi),
        .o_split      (w_split)
    );

    // Beat-holding state machine. A newly accepted element overwrites the
    // held beat in the same cycle that beat is consumed, which gives full
    // throughput. The overflow half of a split element waits in r_hi_* until
    // the first half leaves.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_EMPTY;
            r_addr       <= '0;
            r_byteena    <= '0;
            r_data       <= '0;
            r_last       <= 1'b0;
            r_hi_byteena <= '0;
            r_hi_data    <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_misalign <= w_accept & w_misaligned & !SPLIT_EN;
            case (r_state)
                ST_EMPTY, ST_HOLD: begin
                    if (w_accept) begin
                        r_addr       <= {in_addr[AW-1:OW], {OW{1'b0}}};
                        r_byteena    <= w_en_lo;
                        r_data       <= w_data_lo;
                        r_hi_byteena <= w_en_hi;
                        r_hi_data    <= w_data_hi;
                        r_last       <= !w_split;
                        r_state      <= w_split ? ST_HOLD_LO : ST_HOLD;
                    end else if (w_consume) begin
                        r_last  <= 1'b0;
                        r_state <= ST_EMPTY;
                    end
                end
                ST_HOLD_LO: begin
                    if (w_consume) begin
                        r_addr    <= r_addr + AW'(NB);
                        r_byteena <= r_hi_byteena;
                        r_data    <= r_hi_data;
                        r_last    <= 1'b1;
                        r_state   <= ST_HOLD;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign out_addr     = r_addr;
    assign out_byteena  = r_byteena;
    assign out_data     = r_data;
    assign out_last     = r_last;
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_vstore_data_aligner.sv
// ----------------------------------------------------------------------------
// tb_vstore_data_aligner
// Directed bench for vstore_data_aligner with DW=64. Inputs change on the
// falling clock edge; outputs are sampled 1 ns after the rising edge.
// Split-path scenarios follow VSTORE_SPLIT_UNALIGNED_EN; the rounding and
// misalign_err scenario covers the default build.
// ----------------------------------------------------------------------------
module tb_vstore_data_aligner;

    localparam int DW = 64;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic [AW-1:0] in_addr;
    logic [1:0]    in_size;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [7:0]    out_byteena;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          misalign_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vstore_data_aligner #(
        .DW (DW),
        .AW (AW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_addr      (in_addr),
        .in_size      (in_size),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_byteena  (out_byteena),
        .out_data     (out_data),
        .out_last     (out_last),
        .misalign_err (misalign_err)
    );

    task automatic test_reset();
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_addr   = '0;
        in_size   = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_last, out_addr, out_byteena, out_data, misalign_err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got v=%b l=%b a=%h be=%h d=%h me=%b want all zero",
                     out_valid, out_last, out_addr, out_byteena, out_data, misalign_err);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_byte_lane();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hFFFF_FFFF_FFFF_FFAB;
        in_addr   = 32'h1003;
        in_size   = 2'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 32'h1000 || out_byteena !== 8'h10 ||
            out_data !== 64'h0000_00AB_0000_0000 || out_last !== 1'b1 || misalign_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL byte_beat got v=%b a=%h be=%h d=%h l=%b me=%b want v=1 a=00001000 be=10 d=000000ab00000000 l=1 me=0",
                     out_valid, out_addr, out_byteena, out_data, out_last, misalign_err);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL byte_hold_ready got %b want 0", in_ready);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL byte_passthru_ready got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL byte_drain got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] el_data [4];
        logic [31:0] el_addr [4];
        logic [1:0]  el_size [4];
        logic [31:0] ex_addr [4];
        logic [7:0]  ex_be   [4];
        logic [63:0] ex_data [4];
        el_data[0] = 64'h1122334455667788; el_addr[0] = 32'h2000; el_size[0] = 2'd3;
        ex_addr[0] = 32'h2000; ex_be[0] = 8'hFF; ex_data[0] = 64'h1122334455667788;
        el_data[1] = 64'hCAFEF00D12345678; el_addr[1] = 32'h2008; el_size[1] = 2'd3;
        ex_addr[1] = 32'h2008; ex_be[1] = 8'hFF; ex_data[1] = 64'hCAFEF00D12345678;
        el_data[2] = 64'h000000000000ABCD; el_addr[2] = 32'h2012; el_size[2] = 2'd1;
        ex_addr[2] = 32'h2010; ex_be[2] = 8'h30; ex_data[2] = 64'h0000ABCD00000000;
        el_data[3] = 64'h0000000089ABCDEF; el_addr[3] = 32'h2014; el_size[3] = 2'd2;
        ex_addr[3] = 32'h2010; ex_be[3] = 8'h0F; ex_data[3] = 64'h0000000089ABCDEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = el_data[i];
            in_addr   = el_addr[i];
            in_size   = el_size[i];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_ready[%0d] got %b want 1", i, in_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_addr !== ex_addr[i] || out_byteena !== ex_be[i] ||
                out_data !== ex_data[i] || out_last !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_beat[%0d] got v=%b a=%h be=%h d=%h l=%b want v=1 a=%h be=%h d=%h l=1",
                         i, out_valid, out_addr, out_byteena, out_data, out_last, ex_addr[i], ex_be[i], ex_data[i]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_drain got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h0000000055667788;
        in_addr   = 32'h3004;
        in_size   = 2'd2;
        @(posedge clk);
        #1;
        in_data = 64'h0000000000000099;
        in_addr = 32'h3000;
        in_size = 2'd0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_addr !== 32'h3000 || out_byteena !== 8'h0F ||
                out_data !== 64'h0000000055667788 || out_last !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d] got v=%b a=%h be=%h d=%h l=%b rdy=%b want v=1 a=00003000 be=0f d=0000000055667788 l=1 rdy=0",
                         k, out_valid, out_addr, out_byteena, out_data, out_last, in_ready);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 32'h3000 || out_byteena !== 8'h80 ||
            out_data !== 64'h9900000000000000 || out_last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_next got v=%b a=%h be=%h d=%h l=%b want v=1 a=00003000 be=80 d=9900000000000000 l=1",
                     out_valid, out_addr, out_byteena, out_data, out_last);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_no_dup got out_valid=%b want 0", out_valid);
        end
    endtask

`ifdef VSTORE_SPLIT_UNALIGNED_EN
    task automatic test_split();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h00000000DEADBEEF;
        in_addr   = 32'h1006;
        in_size   = 2'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 32'h1000 || out_byteena !== 8'h03 ||
            out_data !== 64'h000000000000DEAD || out_last !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL split_beat1 got v=%b a=%h be=%h d=%h l=%b rdy=%b want v=1 a=00001000 be=03 d=000000000000dead l=0 rdy=0",
                     out_valid, out_addr, out_byteena, out_data, out_last, in_ready);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL split_lo_ready got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 32'h1008 || out_byteena !== 8'hC0 ||
            out_data !== 64'hBEEF000000000000 || out_last !== 1'b1 || misalign_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL split_beat2 got v=%b a=%h be=%h d=%h l=%b me=%b want v=1 a=00001008 be=c0 d=beef000000000000 l=1 me=0",
                     out_valid, out_addr, out_byteena, out_data, out_last, misalign_err);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 64'h0000000000001234;
        in_addr  = 32'h1001;
        in_size  = 2'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 32'h1000 || out_byteena !== 8'h60 ||
            out_data !== 64'h0012340000000000 || out_last !== 1'b1 || misalign_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL unaligned_true_addr got v=%b a=%h be=%h d=%h l=%b me=%b want v=1 a=00001000 be=60 d=0012340000000000 l=1 me=0",
                     out_valid, out_addr, out_byteena, out_data, out_last, misalign_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL split_drain got out_valid=%b want 0", out_valid);
        end
    endtask
`else
    task automatic test_misalign();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h0000000000001234;
        in_addr   = 32'h1001;
        in_size   = 2'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 32'h1000 || out_byteena !== 8'hC0 ||
            out_data !== 64'h1234000000000000 || out_last !== 1'b1 || misalign_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL misalign_half got v=%b a=%h be=%h d=%h l=%b me=%b want v=1 a=00001000 be=c0 d=1234000000000000 l=1 me=1",
                     out_valid, out_addr, out_byteena, out_data, out_last, misalign_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (misalign_err !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misalign_pulse_end got me=%b v=%b want 0 0", misalign_err, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 64'h00000000DEADBEEF;
        in_addr  = 32'h1006;
        in_size  = 2'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 32'h1000 || out_byteena !== 8'h0F ||
            out_data !== 64'h00000000DEADBEEF || out_last !== 1'b1 || misalign_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL misalign_word got v=%b a=%h be=%h d=%h l=%b me=%b want v=1 a=00001000 be=0f d=00000000deadbeef l=1 me=1",
                     out_valid, out_addr, out_byteena, out_data, out_last, misalign_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (misalign_err !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misalign_word_end got me=%b v=%b want 0 0", misalign_err, out_valid);
        end
    endtask
`endif

    task automatic test_async_reset();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h00000000DEADBEEF;
        in_addr   = 32'h1006;
        in_size   = 2'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL areset_pre got out_valid=%b want 1", out_valid);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_last, out_addr, out_byteena, out_data, misalign_err} !== '0) begin
            errors++;
            $display("[TB] FAIL areset_outputs got v=%b l=%b a=%h be=%h d=%h me=%b want all zero",
                     out_valid, out_last, out_addr, out_byteena, out_data, misalign_err);
        end
        @(negedge clk);
        resetn    = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL areset_ready got %b want 1", in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL areset_no_beat[%0d] got out_valid=%b want 0", k, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_lane();
        test_back_to_back();
        test_backpressure();
`ifdef VSTORE_SPLIT_UNALIGNED_EN
        test_split();
`else
        test_misalign();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
